muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in XLEN.
- It is the sequential counterpart to the single-cycle ALU path: it decodes funct3 for the eight M-extension ops and computes the result over multiple cycles.
- It exchanges operands and results with the execute stage through valid/ready handshakes on both sides.
- It supports a pipeline kill/flush.

Parameters:
- XLEN, 32, operand/result width in bits (must be ≥ 8 and even).
- CNT_W, $clog2(XLEN+1), iteration counter width (derived; do not override).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- valid_i  input  1  operation request valid.
- ready_o  output  1  unit can accept a request (high only in IDLE).
- funct3_i  input  3  M-extension op select.
- rs1_i  input  XLEN  operand A (dividend / multiplicand).
- rs2_i  input  XLEN  operand B (divisor / multiplier).
- kill_i  input  1  abort the in-flight op (pipeline flush).
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  XLEN  result, stable while valid_o is high.
- busy_o  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst_ni low at the edge): state = IDLE, ready_o = 1, valid_o = 0, busy_o = 0, result_o = 0, counter = 0. Reset overrides kill_i and all handshakes.
- Op decode (funct3_i):
  - 000 MUL: low XLEN bits of product.
  - 001 MULH: high bits, signed×signed.
  - 010 MULHSU: high bits, signed rs1 × unsigned rs2.
  - 011 MULHU: high bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Accept: handshake when valid_i && ready_o && !kill_i. On accept, latch the op and the operand magnitudes (absolute value for signed operands), latch the result-sign flags, clear the 2·XLEN accumulator, and set counter = XLEN.
- States:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept, with the result computed in that cycle.
  - CALC -> DONE when the counter reaches 0 after the final iteration.
  - DONE -> IDLE when ready_i is high.
  - Any state -> IDLE when kill_i is high: valid_o drops next cycle and the result is discarded.
- CALC performs one iteration per cycle:
  - Multiply: radix-2 shift-add over the magnitudes.
  - Divide: restoring shift-subtract.
  - counter decrements each cycle.
  - After the last iteration, apply sign correction:
    - Product: negate when the operand signs differ (signed ops only).
    - Quotient: negate when the signs differ.
    - Remainder: takes the sign of the dividend.
- Latency:
  - Normal ops: valid_o rises exactly XLEN+1 cycles after the accepting edge.
  - Special cases: valid_o rises 1 cycle after the accepting edge.
- Special cases (RISC-V defined; no trap):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1) for DIV: quotient = rs1; REM: 0.
- Output hold: in DONE, valid_o = 1 and result_o is held until ready_i. ready_o = 0 in DONE; there is no back-to-back accept in the same cycle as the result handshake. The next accept happens no earlier than the cycle after returning to IDLE.
- kill_i coinciding with valid_i in IDLE: no accept.
- kill_i in DONE together with ready_i: treated as kill (result dropped).
- result_o value when valid_o = 0: don't-care for consumers; the implementation holds the last value.
- Invariants:
  - ready_o == (state == IDLE).
  - valid_o == (state == DONE).

Decomposition:
- Add to params_pkg:
  - FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU, FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU constants.
  - muldiv_state_t enum {IDLE, CALC, DONE}.
  - A packed muldiv_op_t struct {is_div, is_high, a_signed, b_signed, want_rem}.
- Sub-module muldiv_op_decoder: combinational funct3 -> muldiv_op_t. It is instantiated once; the FSM and datapath stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) -> result 0xFFFFFFEB; valid_o at accept+33 cycles; ready_o low throughout.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each with valid_o at accept+1.
- Back-pressure and kill:
  - Hold ready_i low 5 cycles in DONE -> result_o and valid_o stable, then one-cycle handshake returns to IDLE.
  - Assert kill_i at CALC cycle 10 -> IDLE next cycle, valid_o never rises.
  - Assert kill_i together with valid_i -> no accept.
- Reset: drive rst_ni low mid-CALC -> next edge: IDLE, ready_o = 1, valid_o = 0, result_o = 0.
- Run the same directed checks with XLEN = 16 against a reference model.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op-decode constants, FSM state encoding and the decoded-op bundle.
package muldiv_unit_pkg;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   typedef struct packed {
      logic is_div;
      logic is_high;
      logic a_signed;
      logic b_signed;
      logic want_rem;
   } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit_op_decoder.sv
// Combinational funct3 decode into the operation attributes used by the datapath.
// MUL is decoded as unsigned: the low half of the product is sign-agnostic.
module muldiv_op_decoder
   import muldiv_unit_pkg::*;
(
   input  logic [2:0] i_funct3,
   output muldiv_op_t o_op
);

   // Map each M-extension op to its signedness / result-select flags.
   always_comb begin
      o_op = '0;
      case (i_funct3)
         FUNCT3_MUL:    o_op = '0;
         FUNCT3_MULH:   begin o_op.is_high = 1'b1; o_op.a_signed = 1'b1; o_op.b_signed = 1'b1; end
         FUNCT3_MULHSU: begin o_op.is_high = 1'b1; o_op.a_signed = 1'b1; end
         FUNCT3_MULHU:  o_op.is_high = 1'b1;
         FUNCT3_DIV:    begin o_op.is_div = 1'b1; o_op.a_signed = 1'b1; o_op.b_signed = 1'b1; end
         FUNCT3_DIVU:   o_op.is_div = 1'b1;
         FUNCT3_REM:    begin o_op.is_div = 1'b1; o_op.a_signed = 1'b1; o_op.b_signed = 1'b1; o_op.want_rem = 1'b1; end
         FUNCT3_REMU:   begin o_op.is_div = 1'b1; o_op.want_rem = 1'b1; end
         default:       o_op = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up on the last step.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   muldiv_state_t     r_state, w_state_next;
   muldiv_op_t        w_op;
   logic              r_is_div, r_is_high, r_want_rem, r_neg;
   logic [XLEN-1:0]   r_a, r_b, r_result;
   logic [2*XLEN-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept, w_a_neg, w_b_neg, w_div_zero, w_overflow, w_special;
   logic [XLEN-1:0]   w_rs1_mag, w_rs2_mag, w_special_res, w_addend;
   logic [XLEN-1:0]   w_quo_rem, w_div_res, w_final;
   logic [XLEN:0]     w_mul_sum, w_rem_shift, w_div_diff;
   logic [2*XLEN-1:0] w_step_acc, w_prod;

   muldiv_op_decoder u_decoder (
      .i_funct3 (funct3_i),
      .o_op     (w_op)
   );

   assign w_accept   = valid_i & (r_state == IDLE) & ~kill_i;
   assign w_a_neg    = w_op.a_signed & rs1_i[XLEN-1];
   assign w_b_neg    = w_op.b_signed & rs2_i[XLEN-1];
   assign w_rs1_mag  = w_a_neg ? ('0 - rs1_i) : rs1_i;
   assign w_rs2_mag  = w_b_neg ? ('0 - rs2_i) : rs2_i;
   assign w_div_zero = w_op.is_div & (rs2_i == '0);
   assign w_overflow = w_op.is_div & w_op.a_signed & (rs1_i == MOST_NEG) & (rs2_i == ALL_ONES);
   assign w_special  = w_div_zero | w_overflow;

   // Architecturally defined results for divide-by-zero and signed overflow.
   always_comb begin
      w_special_res = '0;
      if (w_div_zero) begin
         w_special_res = w_op.want_rem ? rs1_i : ALL_ONES;
      end else begin
         w_special_res = w_op.want_rem ? '0 : rs1_i;
      end
   end

   // Multiply keeps the multiplier in r_b (shifted right); divide streams the
   // dividend out of r_a MSB-first, remainder in the upper accumulator half.
   assign w_addend    = r_b[0] ? r_a : '0;
   assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
   assign w_rem_shift = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
   assign w_div_diff  = w_rem_shift - {1'b0, r_b};

   // One shift-add or restoring shift-subtract step.
   always_comb begin
      w_step_acc = r_acc;
      if (r_is_div) begin
         if (w_div_diff[XLEN]) begin
            w_step_acc = {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
         end else begin
            w_step_acc = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
         end
      end else begin
         w_step_acc = {w_mul_sum, r_acc[XLEN-1:1]};
      end
   end

   assign w_prod    = r_neg ? ('0 - w_step_acc) : w_step_acc;
   assign w_quo_rem = r_want_rem ? w_step_acc[2*XLEN-1:XLEN] : w_step_acc[XLEN-1:0];
   assign w_div_res = r_neg ? ('0 - w_quo_rem) : w_quo_rem;
   assign w_final   = r_is_div ? w_div_res
                    : (r_is_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a kill wins over every handshake.
   always_comb begin
      w_state_next = r_state;
      if (kill_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_state_next = w_special ? DONE : CALC;
               end else begin
                  w_state_next = IDLE;
               end
            end
            CALC: begin
               if (r_cnt == CNT_W'(1)) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = CALC;
               end
            end
            DONE: begin
               if (ready_i) begin
                  w_state_next = IDLE;
               end else begin
                  w_state_next = DONE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // Operand capture, iteration and result latch.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_is_div   <= 1'b0;
         r_is_high  <= 1'b0;
         r_want_rem <= 1'b0;
         r_neg      <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_is_div   <= w_op.is_div;
                  r_is_high  <= w_op.is_high;
                  r_want_rem <= w_op.want_rem;
                  r_neg      <= w_op.want_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
                  r_a        <= w_rs1_mag;
                  r_b        <= w_rs2_mag;
                  r_acc      <= '0;
                  r_cnt      <= CNT_W'(XLEN);
                  if (w_special) begin
                     r_result <= w_special_res;
                  end
               end
            end
            CALC: begin
               if (!kill_i) begin
                  r_acc <= w_step_acc;
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_is_div) begin
                     r_a <= {r_a[XLEN-2:0], 1'b0};
                  end else begin
                     r_b <= {1'b0, r_b[XLEN-1:1]};
                  end
                  if (r_cnt == CNT_W'(1)) begin
                     r_result <= w_final;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o  = (r_state == IDLE);
   assign valid_o  = (r_state == DONE);
   assign busy_o   = (r_state != IDLE);
   assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=16, checked against an
// arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        sel16 = 1'b0;
   logic        kill = 1'b0;
   logic        rdy = 1'b0;
   logic [2:0]  f3 = 3'd0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;

   logic        v32_in, v16_in;
   logic        vo32, vo16, ro32, ro16, b32, b16;
   logic [31:0] r32;
   logic [15:0] r16;
   logic        m_valid, m_ready, m_busy;
   logic [31:0] m_result;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [2:0]  f3_q[$];

   always #5 clk = ~clk;

   assign v32_in   = valid & ~sel16;
   assign v16_in   = valid & sel16;
   assign m_valid  = sel16 ? vo16 : vo32;
   assign m_ready  = sel16 ? ro16 : ro32;
   assign m_busy   = sel16 ? b16 : b32;
   assign m_result = sel16 ? {16'h0000, r16} : r32;

   muldiv_unit #(.XLEN(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v32_in), .ready_o(ro32), .funct3_i(f3),
      .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill), .valid_o(vo32), .ready_i(rdy),
      .result_o(r32), .busy_o(b32)
   );

   muldiv_unit #(.XLEN(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v16_in), .ready_o(ro16), .funct3_i(f3),
      .rs1_i(rs1[15:0]), .rs2_i(rs2[15:0]), .kill_i(kill), .valid_o(vo16), .ready_i(rdy),
      .result_o(r16), .busy_o(b16)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic longint to_signed(input longint u, input int xl);
      if (((u >> (xl - 1)) & 64'd1) != 0) return u - (longint'(1) << xl);
      return u;
   endfunction

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input int xl);
      longint mask, ua, ub, sa, sb, minv, res;
      longint unsigned uprod;
      mask = (longint'(1) << xl) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = to_signed(ua, xl);
      sb   = to_signed(ub, xl);
      minv = -(longint'(1) << (xl - 1));
      case (f)
         3'd0: res = sa * sb;
         3'd1: res = (sa * sb) >>> xl;
         3'd2: res = (sa * ub) >>> xl;
         3'd3: begin
            uprod = $unsigned(ua) * $unsigned(ub);
            res   = longint'(uprod >> xl);
         end
         3'd4: res = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
         3'd5: res = (ub == 0) ? -1 : ua / ub;
         3'd6: res = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
         default: res = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(res & mask);
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b, input int xl);
      longint mask, sa, sb;
      mask = (longint'(1) << xl) - 1;
      sa   = to_signed(longint'(a) & mask, xl);
      sb   = to_signed(longint'(b) & mask, xl);
      if (!f[2]) return 1'b0;
      if ((longint'(b) & mask) == 0) return 1'b1;
      return (!f[0] && sa == -(longint'(1) << (xl - 1)) && sb == -1);
   endfunction

   // Scoreboard monitor: compare every result handshake against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && m_valid && rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: unexpected result %h, none required", m_result);
         end else begin
            logic [31:0] e;
            logic [2:0]  f;
            e = exp_q.pop_front();
            f = f3_q.pop_front();
            if (m_result !== e) begin
               n_bad++;
               $display("FAIL result funct3=%0d w16=%0d: got %h required %h", f, sel16, m_result, e);
            end
         end
      end
   end

   task automatic wait_ready();
      for (int k = 0; k < 200 && !m_ready; k++) begin
         @(posedge clk); #1;
      end
      check("ready before issue", {31'd0, m_ready}, 32'd1);
   endtask

   task automatic run_op(input bit w16, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      int          xl, lat, cyc;
      bit          rdy_low_ok, stable_ok;
      logic [31:0] mask, exp;
      xl   = w16 ? 16 : 32;
      mask = w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      a    = a & mask;
      b    = b & mask;
      exp  = ref_model(f, a, b, xl);
      lat  = is_special(f, a, b, xl) ? 1 : xl + 1;
      sel16 = w16;
      wait_ready();
      f3 = f; rs1 = a; rs2 = b; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      exp_q.push_back(exp);
      f3_q.push_back(f);
      cyc = 1;
      rdy_low_ok = 1'b1;
      while (!m_valid && cyc < xl + 10) begin
         if (m_ready) rdy_low_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("latency f3=%0d", f), cyc, lat);
      check("ready_o low while busy", {31'd0, rdy_low_ok}, 32'd1);
      if (!m_valid) begin
         void'(exp_q.pop_back());
         void'(f3_q.pop_back());
         return;
      end
      if (hold > 0) begin
         stable_ok = 1'b1;
         for (int h = 0; h < hold; h++) begin
            if (!m_valid || m_result !== exp || m_ready) stable_ok = 1'b0;
            @(posedge clk); #1;
         end
         check("held result stable", {31'd0, stable_ok}, 32'd1);
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      check("idle after handshake", {30'd0, m_ready, m_valid}, 32'd2);
   endtask

   task automatic kill_tests(input bit w16);
      int xl;
      bit never_valid;
      xl = w16 ? 16 : 32;
      sel16 = w16;
      wait_ready();
      f3 = 3'd0; rs1 = 32'd12345; rs2 = 32'd678; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill in CALC -> idle", {29'd0, m_ready, m_busy, m_valid}, 32'd4);
      rdy = 1'b1;
      never_valid = 1'b1;
      for (int i = 0; i < xl + 5; i++) begin
         if (m_valid) never_valid = 1'b0;
         @(posedge clk); #1;
      end
      rdy = 1'b0;
      check("no result after kill", {31'd0, never_valid}, 32'd1);
      f3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; kill = 1'b0;
      check("kill with valid -> no accept", {30'd0, m_ready, m_busy}, 32'd2);
   endtask

   task automatic reset_test(input bit w16);
      sel16 = w16;
      wait_ready();
      f3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("reset mid-CALC state", {29'd0, m_ready, m_valid, m_busy}, 32'd4);
      check("reset mid-CALC result", m_result, 32'd0);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pick(input int xl);
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000 >> (32 - xl);
         4: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic run_suite(input bit w16);
      int          xl;
      logic [31:0] mn;
      xl = w16 ? 16 : 32;
      mn = 32'h8000_0000 >> (32 - xl);
      run_op(w16, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(w16, 3'd1, mn, mn, 0);
      run_op(w16, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      run_op(w16, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(w16, 3'd4, 32'hFFFF_FFF9, 32'd2, 5);
      run_op(w16, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(w16, 3'd5, 32'd100, 32'd7, 0);
      run_op(w16, 3'd7, 32'd100, 32'd7, 0);
      run_op(w16, 3'd5, 32'd5, 32'd0, 0);
      run_op(w16, 3'd6, 32'd5, 32'd0, 2);
      run_op(w16, 3'd4, mn, 32'hFFFF_FFFF, 0);
      run_op(w16, 3'd6, mn, 32'hFFFF_FFFF, 0);
      for (int i = 0; i < 30; i++) begin
         run_op(w16, 3'($urandom_range(0, 7)), pick(xl), pick(xl), int'($urandom_range(0, 2)));
      end
      kill_tests(w16);
      reset_test(w16);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset state 32", {28'd0, ro32, vo32, b32, 1'b0}, 32'd8);
      check("reset result 32", r32, 32'd0);
      check("reset state 16", {28'd0, ro16, vo16, b16, 1'b0}, 32'd8);
      check("reset result 16", {16'd0, r16}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_suite(1'b0);
      run_suite(1'b1);
      repeat (3) @(posedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule
